// File: rtl/tmul_pkg.sv
// Shared types and helpers for the multi-channel temporal-unary multiplier.
package tmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CH    = 4;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tmul_uni_mc_if.sv
// Handshake/bus bundle for tmul_uni_mc; oCnt exists only with TMUL_OUT_CNT_EN defined.
interface tmul_uni_mc_if
  import tmul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CH    = DEF_CH
);
  logic [WIDTH-1:0]    iA;
  logic                iA_valid;
  logic                iA_ready;
  logic [CH*WIDTH-1:0] iB;
  logic                loadB;
  logic [WIDTH-1:0]    sobolSeq;
  logic [CH-1:0]       oC;
  logic                busy;
  logic                done;
`ifdef TMUL_OUT_CNT_EN
  logic [CH*WIDTH-1:0] oCnt;
`endif

  modport master (
    output iA, iA_valid, iB, loadB, sobolSeq,
`ifdef TMUL_OUT_CNT_EN
    input  oCnt,
`endif
    input  iA_ready, oC, busy, done
  );

  modport slave (
    input  iA, iA_valid, iB, loadB, sobolSeq,
`ifdef TMUL_OUT_CNT_EN
    output oCnt,
`endif
    output iA_ready, oC, busy, done
  );

endinterface

// File: rtl/tmul_uni_lane.sv
// One channel: frozen B operand, strict compare against the shared Sobol value,
// optional ones-counter (TMUL_OUT_CNT_EN).
module tmul_uni_lane
  import tmul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] b,
  input  logic             run,
  input  logic [WIDTH-1:0] sobol,
`ifdef TMUL_OUT_CNT_EN
  input  logic             clear,
  output logic [WIDTH-1:0] ones,
`endif
  output logic             c
);

  logic [WIDTH-1:0] bbuf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbuf <= '0;
    end else if (load) begin
      bbuf <= b;
    end
  end

  always_comb begin
    c = run && (bbuf > sobol);
  end

`ifdef TMUL_OUT_CNT_EN
  // count never exceeds the window length, so no saturation is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
    end else if (clear) begin
      ones <= '0;
    end else if (c) begin
      ones <= ones + WIDTH'(1);
    end
  end
`endif

endmodule

// File: rtl/tmul_uni_mc.sv
// Multi-channel temporal-unary multiplier: iA sets a window of RUN cycles gating CH
// rate-coded B streams. Optional per-channel ones-counters under TMUL_OUT_CNT_EN.
module tmul_uni_mc
  import tmul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CH    = DEF_CH
) (
  input  logic         clk,
  input  logic         rst,
  tmul_uni_mc_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic             handshake;
  logic             load_en;
  logic             run;
  logic [CH-1:0]    c_vec;

  always_comb begin
    handshake = (state == IDLE) && bus.iA_valid;
    load_en   = bus.loadB && (state != RUN);
    run       = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iA_valid) begin
            cnt <= bus.iA;
            if (bus.iA != '0) begin
              state  <= RUN;
              busy_r <= 1'b1;
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          // stops at cnt==1, so an all-ones iA never wraps the counter
          cnt <= cnt - WIDTH'(1);
          if (cnt == WIDTH'(1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iA_ready = (state == IDLE);
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.oC       = c_vec;

`ifdef TMUL_OUT_CNT_EN
  logic [WIDTH-1:0] ones_arr [CH];

  always_comb begin
    bus.oCnt = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      bus.oCnt[k*WIDTH +: WIDTH] = ones_arr[k];
    end
  end
`endif

  for (genvar k = 0; k < CH; k++) begin : g_lane
    localparam int unsigned LSB = lane_lsb(k, WIDTH);
    tmul_uni_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load_en),
      .b     (bus.iB[LSB +: WIDTH]),
      .run   (run),
      .sobol (bus.sobolSeq),
`ifdef TMUL_OUT_CNT_EN
      .clear (handshake),
      .ones  (ones_arr[k]),
`endif
      .c     (c_vec[k])
    );
  end

endmodule

// File: tb/tb_tmul_uni_mc.sv
// Directed, table-driven bench for tmul_uni_mc; oCnt checks only with TMUL_OUT_CNT_EN.
module tb_tmul_uni_mc;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  typedef struct {
    string            name;
    logic [7:0]       a;
    logic [3:0][7:0]  b;
    logic [7:0]       s;
    logic [3:0]       oc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  tmul_uni_mc_if #(.WIDTH(W), .CH(N)) bus ();

  tmul_uni_mc #(.WIDTH(W), .CH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [3:0] oc, input int unsigned len);
`ifdef TMUL_OUT_CNT_EN
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_ocnt%0d", name, k), {24'b0, bus.oCnt[k*8 +: 8]}, oc[k] ? len : 0);
    end
`endif
  endtask

  task automatic start(input logic [7:0] a, input logic [3:0][7:0] b,
                       input logic [7:0] s, input bit load);
    @(negedge clk);
    check("start_ready", {31'b0, bus.iA_ready}, 1);
    bus.iA       = a;
    bus.iA_valid = 1'b1;
    bus.iB       = b;
    bus.loadB    = load;
    bus.sobolSeq = s;
    @(posedge clk);
    #1;
    bus.iA_valid = 1'b0;
    bus.loadB    = 1'b0;
  endtask

  // Follows a window from just after the handshake through the idle cycle after done.
  task automatic observe(input string name, input logic [3:0] exp_oc,
                         input int unsigned exp_len, input bit inject);
    int unsigned run_n = 0;
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check({name, "_done_oc"}, {28'b0, bus.oC}, 0);
        check({name, "_done_busy"}, {31'b0, bus.busy}, 0);
        check({name, "_done_ready"}, {31'b0, bus.iA_ready}, 0);
      end else begin
        check({name, "_busy"}, {31'b0, bus.busy}, 1);
        check({name, "_oc"}, {28'b0, bus.oC}, {28'b0, exp_oc});
        check({name, "_run_ready"}, {31'b0, bus.iA_ready}, 0);
        run_n++;
        if (inject && run_n == 2) begin
          bus.iA       = 8'd3;
          bus.iA_valid = 1'b1;
          bus.iB       = {4{8'd255}};
          bus.loadB    = 1'b1;
        end
      end
    end
    check({name, "_done_seen"}, {31'b0, seen}, 1);
    check({name, "_len"}, run_n, exp_len);
    check_cnt(name, exp_oc, exp_len);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, bus.done}, 0);
    check({name, "_idle_ready"}, {31'b0, bus.iA_ready}, 1);
    check({name, "_idle_oc"}, {28'b0, bus.oC}, 0);
  endtask

  vec_t vecs [7];

  initial begin
    int unsigned ones;
    int unsigned runs;
    bit          ended;

    vecs[0] = '{"basic",   8'd5, {8'd0,   8'd100, 8'd50,  8'd200}, 8'd100, 4'b0001};
    vecs[1] = '{"lowsob",  8'd3, {8'd255, 8'd255, 8'd0,   8'd1},   8'd0,   4'b1101};
    vecs[2] = '{"allones", 8'd4, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 4'b0000};
    vecs[3] = '{"strict",  8'd1, {8'd0,   8'd127, 8'd129, 8'd128}, 8'd128, 4'b0010};
    vecs[4] = '{"zero",    8'd0, {8'd1,   8'd2,   8'd3,   8'd4},   8'd0,   4'b0000};
    vecs[5] = '{"mixed",   8'd2, {8'd10,  8'd20,  8'd30,  8'd40},  8'd25,  4'b0011};
    vecs[6] = '{"top",     8'd7, {8'd200, 8'd0,   8'd0,   8'd0},   8'd199, 4'b1000};

    bus.iA = '0; bus.iA_valid = 1'b0; bus.iB = '0; bus.loadB = 1'b0; bus.sobolSeq = '0;

    #12;
    check("rst_ready", {31'b0, bus.iA_ready}, 1);
    check("rst_busy",  {31'b0, bus.busy}, 0);
    check("rst_done",  {31'b0, bus.done}, 0);
    check("rst_oc",    {28'b0, bus.oC}, 0);
    check_cnt("rst", 4'b0000, 0);
    @(negedge clk);
    rst = 1'b0;

    // loadB and iA_valid together: new B applies to the whole window
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1);
      observe(vecs[i].name, vecs[i].oc, vecs[i].a, 1'b0);
    end

    // Sobol ramp over a maximum-length window
    bus.sobolSeq = 8'd0;
    start(8'd255, {8'd0, 8'd0, 8'd0, 8'd64}, 8'd0, 1'b1);
    ones = 0; runs = 0; ended = 1'b0;
    for (int n = 0; n < 300 && !ended; n++) begin
      @(negedge clk);
      if (bus.done) begin
        ended = 1'b1;
      end else begin
        if (bus.busy) runs++;
        if (bus.oC[0]) ones++;
        @(posedge clk);
        #1 bus.sobolSeq = bus.sobolSeq + 8'd1;
      end
    end
    check("ramp_done_seen", {31'b0, ended}, 1);
    check("ramp_busy_len", runs, 255);
    check("ramp_ones", ones, 64);
`ifdef TMUL_OUT_CNT_EN
    check("ramp_ocnt0", {24'b0, bus.oCnt[7:0]}, 64);
    check("ramp_ocnt_hi", {8'b0, bus.oCnt[31:8]}, 0);
`endif
    @(negedge clk);

    // iA_valid and loadB held from mid-RUN: ignored until IDLE, then taken together
    start(8'd4, {8'd0, 8'd100, 8'd50, 8'd200}, 8'd100, 1'b1);
    observe("proto_w1", 4'b0001, 4, 1'b1);
    @(posedge clk);
    #1;
    bus.iA_valid = 1'b0;
    bus.loadB    = 1'b0;
    observe("proto_w2", 4'b1111, 3, 1'b0);

    // Reset in the middle of a window
    start(8'd10, {8'd0, 8'd0, 8'd0, 8'd200}, 8'd100, 1'b1);
    @(negedge clk);
    check("mid_busy", {31'b0, bus.busy}, 1);
    @(negedge clk);
    check("mid_oc", {28'b0, bus.oC}, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oc",    {28'b0, bus.oC}, 0);
    check("mid_rst_busy",  {31'b0, bus.busy}, 0);
    check("mid_rst_done",  {31'b0, bus.done}, 0);
    check("mid_rst_ready", {31'b0, bus.iA_ready}, 1);
    check_cnt("mid_rst", 4'b0000, 0);
    @(negedge clk);
    rst = 1'b0;
    // B buffers were cleared by reset, so no loadB means all-zero output
    start(8'd2, {4{8'd255}}, 8'd0, 1'b0);
    observe("post_rst", 4'b0000, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
